// File: rtl/ram_slot_arbiter.sv
// ram_slot_arbiter: time-slot arbiter sharing one synchronous RAM between video, CPU and DMA.
// Two-stage pipeline: grant -> RAM access -> ack, with up to two accesses in flight.
module ram_slot_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        slot_en,
  output logic        slot_is_video,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  typedef enum logic [1:0] {NONE, VID, CPU, DMA} own_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  own_t        win, s1_own, s2_own;
  logic        s2_we, out_v, out_c, out_d, e_v, e_c, e_d, win_we;
  logic [14:0] win_addr;
  logic [7:0]  win_wdata;
  logic [3:0]  starve_cnt;
  always_comb begin
    e_v = vid_req & ~out_v;
    e_c = cpu_req & ~out_c;
    e_d = dma_req & ~out_d;
    win = !slot_en ? NONE :
          slot_is_video ? (e_v ? VID : e_d ? DMA : NONE) :
          (starve_cnt == LIM && e_d) ? DMA : e_c ? CPU : e_d ? DMA : NONE;
    win_we = win == CPU ? cpu_we : win == DMA ? dma_we : 1'b0;
    win_addr = win == VID ? vid_addr : win == CPU ? cpu_addr : dma_addr;
    win_wdata = win == CPU ? cpu_wdata : dma_wdata;
  end
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      slot_is_video <= 1'b1;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      s1_own <= NONE;
      s2_own <= NONE;
      s2_we <= 1'b0;
      {vid_ack, cpu_ack, dma_ack} <= '0;
      vid_data <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      {out_v, out_c, out_d} <= '0;
      starve_cnt <= '0;
    end else begin
      if (slot_en) slot_is_video <= ~slot_is_video;
      mem_en <= win != NONE;
      mem_we <= win_we;
      if (win != NONE) begin
        mem_addr <= win_addr;
        mem_wdata <= win_wdata;
      end
      s1_own <= win;
      s2_own <= s1_own;
      s2_we <= mem_we;
      vid_ack <= s2_own == VID;
      cpu_ack <= s2_own == CPU;
      dma_ack <= s2_own == DMA;
      if (s2_own == VID) vid_data <= mem_rdata;
      if (s2_own == CPU && !s2_we) cpu_rdata <= mem_rdata;
      if (s2_own == DMA && !s2_we) dma_rdata <= mem_rdata;
      // outstanding clears on the ack edge; a same-edge regrant is impossible since it was still set
      out_v <= (out_v & (s2_own != VID)) | (win == VID);
      out_c <= (out_c & (s2_own != CPU)) | (win == CPU);
      out_d <= (out_d & (s2_own != DMA)) | (win == DMA);
      if (win == DMA) starve_cnt <= '0;
      else if (!slot_is_video && e_d && win == CPU && starve_cnt != LIM) starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_ram_slot_arbiter.sv
// tb_ram_slot_arbiter: directed self-checking bench for ram_slot_arbiter.
module tb_ram_slot_arbiter;
  logic        clk = 0, RESET = 1, slot_en = 0;
  logic        slot_is_video;
  logic        vid_req = 0, cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [14:0] vid_addr = 0, cpu_addr = 0, dma_addr = 0;
  logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
  logic        vid_ack, cpu_ack, dma_ack, mem_en, mem_we;
  logic [7:0]  vid_data, cpu_rdata, dma_rdata, mem_wdata;
  logic [14:0] mem_addr;
  logic [7:0]  mem_rdata = 0, w100 = 0;
  int vectors = 0, miscompares = 0;

  ram_slot_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .RESET(RESET), .slot_en(slot_en), .slot_is_video(slot_is_video),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: fixed contents except one writable byte at 0x0100
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we && mem_addr == 15'h0100) w100 <= mem_wdata;
      mem_rdata <= mem_addr == 15'h0100 ? w100 : mem_addr == 15'h1234 ? 8'hA5 :
                   mem_addr == 15'h0200 ? 8'h11 : mem_addr == 15'h0300 ? 8'h22 : 8'h00;
    end

  task automatic pulse;
    @(negedge clk) slot_en = 1;
    @(negedge clk) slot_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    idle(2);
    vectors++; if ({vid_ack, cpu_ack, dma_ack, mem_en, mem_we} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl got %b want 00000", {vid_ack, cpu_ack, dma_ack, mem_en, mem_we}); end
    vectors++; if (slot_is_video !== 1'b1) begin miscompares++; $display("FAIL reset_phase got %b want 1", slot_is_video); end
    vectors++; if ({mem_addr, mem_wdata, vid_data, cpu_rdata, dma_rdata} !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, vid_data, cpu_rdata, dma_rdata}); end
    RESET = 0;
  endtask

  task automatic test_video;
    vid_req = 1; vid_addr = 15'h1234;
    for (int i = 0; i < 2; i++) begin
      pulse;
      vectors++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 15'h1234}) begin miscompares++; $display("FAIL video_grant[%0d] got en/we/addr %b/%b/%h want 1/0/1234", i, mem_en, mem_we, mem_addr); end
      idle(2);
      vectors++; if ({vid_ack, vid_data} !== {1'b1, 8'hA5}) begin miscompares++; $display("FAIL video_ack[%0d] got %b/%h want 1/a5", i, vid_ack, vid_data); end
      idle(1);
      vectors++; if (vid_ack !== 1'b0) begin miscompares++; $display("FAIL video_ack_pulse[%0d] got %b want 0", i, vid_ack); end
      pulse;
      vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL video_pslot_idle[%0d] got %b want 0", i, mem_en); end
      idle(3);
    end
    vid_req = 0;
  endtask

  task automatic test_cpu_rw;
    vectors++; if (slot_is_video !== 1'b1) begin miscompares++; $display("FAIL cpu_phase got %b want 1", slot_is_video); end
    pulse; idle(3);
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0100; cpu_wdata = 8'h3C;
    pulse;
    vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 15'h0100, 8'h3C}) begin miscompares++; $display("FAIL cpu_write_grant got %b/%b/%h/%h want 1/1/0100/3c", mem_en, mem_we, mem_addr, mem_wdata); end
    idle(1);
    vectors++; if ({mem_en, mem_we} !== 2'b00) begin miscompares++; $display("FAIL cpu_write_oneshot got %b/%b want 0/0", mem_en, mem_we); end
    idle(1);
    vectors++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h00}) begin miscompares++; $display("FAIL cpu_write_ack got %b/%h want 1/00", cpu_ack, cpu_rdata); end
    cpu_req = 0; cpu_we = 0;
    idle(1);
    pulse; idle(3);
    cpu_req = 1;
    pulse;
    vectors++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 15'h0100}) begin miscompares++; $display("FAIL cpu_read_grant got %b/%b/%h want 1/0/0100", mem_en, mem_we, mem_addr); end
    idle(2);
    vectors++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h3C}) begin miscompares++; $display("FAIL cpu_readback got %b/%h want 1/3c", cpu_ack, cpu_rdata); end
    cpu_req = 0;
    idle(1);
  endtask

  task automatic test_starve;
    vid_req = 1; vid_addr = 15'h1234;
    cpu_req = 1; cpu_addr = 15'h0200;
    dma_req = 1; dma_addr = 15'h0300;
    for (int k = 0; k < 10; k++) begin
      pulse;
      vectors++; if (mem_addr !== 15'h1234) begin miscompares++; $display("FAIL starve_vslot[%0d] got %h want 1234", k, mem_addr); end
      idle(3);
      pulse;
      vectors++; if (mem_addr !== (k % 5 == 4 ? 15'h0300 : 15'h0200)) begin miscompares++; $display("FAIL starve_pslot[%0d] got %h want %h", k, mem_addr, (k % 5 == 4 ? 15'h0300 : 15'h0200)); end
      if (k % 5 == 4) begin
        vectors++; if (dut.starve_cnt !== 4'd0) begin miscompares++; $display("FAIL starve_clear[%0d] got %0d want 0", k, dut.starve_cnt); end
      end
      idle(3);
    end
    vid_req = 0; cpu_req = 0; dma_req = 0;
  endtask

  task automatic test_back_to_back;
    dma_req = 1; dma_addr = 15'h0100;
    @(negedge clk) slot_en = 1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      vectors++; if ({mem_en, dma_ack} !== {k % 3 == 0, k % 3 == 2}) begin miscompares++; $display("FAIL b2b[%0d] got en/ack %b/%b want %b/%b", k, mem_en, dma_ack, k % 3 == 0, k % 3 == 2); end
      if (k % 3 == 2) begin
        vectors++; if (dma_rdata !== 8'h3C) begin miscompares++; $display("FAIL b2b_data[%0d] got %h want 3c", k, dma_rdata); end
      end
    end
    slot_en = 0; dma_req = 0;
    pulse;
    vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b want 0", mem_en); end
    idle(3);
  endtask

  task automatic test_overlap;
    vid_req = 1; vid_addr = 15'h1234;
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0200;
    dma_req = 1; dma_addr = 15'h0300;
    @(negedge clk) slot_en = 1;
    @(negedge clk);
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 15'h1234}) begin miscompares++; $display("FAIL ovl_vgrant got %b/%h want 1/1234", mem_en, mem_addr); end
    @(negedge clk) slot_en = 0;
    vectors++; if ({mem_en, mem_addr, vid_ack} !== {1'b1, 15'h0200, 1'b0}) begin miscompares++; $display("FAIL ovl_cgrant got %b/%h/%b want 1/0200/0", mem_en, mem_addr, vid_ack); end
    @(negedge clk);
    vectors++; if ({vid_ack, vid_data, cpu_ack} !== {1'b1, 8'hA5, 1'b0}) begin miscompares++; $display("FAIL ovl_vack got %b/%h/%b want 1/a5/0", vid_ack, vid_data, cpu_ack); end
    vid_req = 0; cpu_req = 0; dma_req = 0;
    @(negedge clk);
    vectors++; if ({cpu_ack, cpu_rdata, vid_ack, dma_ack} !== {1'b1, 8'h11, 2'b00}) begin miscompares++; $display("FAIL ovl_cack got %b/%h/%b/%b want 1/11/0/0", cpu_ack, cpu_rdata, vid_ack, dma_ack); end
    idle(2);
  endtask

  task automatic test_reset_mid;
    vid_req = 1; vid_addr = 15'h1234;
    pulse;
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("FAIL rstmid_grant got %b want 1", mem_en); end
    RESET = 1;
    #1;
    vectors++; if ({mem_en, vid_ack} !== 2'b00) begin miscompares++; $display("FAIL rstmid_drop got %b/%b want 0/0", mem_en, vid_ack); end
    vid_req = 0;
    pulse;
    RESET = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (vid_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_noack[%0d] got %b want 0", k, vid_ack); end
    end
    vectors++; if (slot_is_video !== 1'b1) begin miscompares++; $display("FAIL rstmid_phase got %b want 1", slot_is_video); end
    vid_req = 1;
    pulse;
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 15'h1234}) begin miscompares++; $display("FAIL rstmid_regrant got %b/%h want 1/1234", mem_en, mem_addr); end
    idle(2);
    vectors++; if ({vid_ack, vid_data} !== {1'b1, 8'hA5}) begin miscompares++; $display("FAIL rstmid_ack got %b/%h want 1/a5", vid_ack, vid_data); end
    vid_req = 0;
    idle(2);
  endtask

  initial begin
    test_reset;
    test_video;
    test_cpu_rw;
    test_starve;
    test_back_to_back;
    test_overlap;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_slot_arbiter.md
# ram_slot_arbiter

Time-slot arbiter for the shared 32 KiB system RAM. It multiplexes one synchronous single-port RAM between three requesters: video fetch (hard real-time), MOS6502 (CPU), and a DMA port for the SD loader. Slots alternate between video and processor phases, and a starvation guard bounds how long the DMA requester can be locked out. It sits between the timing generator's slot strobe and the RAM array in the top level.

## Interface
- STARVE_LIMIT, 4: number of consecutive P-slots in which DMA may lose to the CPU before it is forced a grant (1..15).
- clk  in  1  system pixel clock; all logic rises on this edge.
- RESET  in  1  asynchronous, active-high reset.
- slot_en  in  1  one-cycle strobe; each sampled high starts one RAM slot.
- slot_is_video  out  1  type of the next slot to be issued (1 = V-slot).
- vid_req  in  1  video read request (level).
- vid_addr  in  15  video read address.
- vid_ack  out  1  one-cycle pulse: vid_data valid.
- vid_data  out  8  registered read data.
- cpu_req, cpu_we  in  1 each  CPU request, write enable.
- cpu_addr  in  15  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  CPU read data.
- dma_req, dma_we  in  1 each  DMA request, write enable.
- dma_addr  in  15  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_ack  out  1  one-cycle completion pulse.
- dma_rdata  out  8  DMA read data.
- mem_en, mem_we  out  1 each  RAM enable and write strobe (registered).
- mem_addr  out  15  RAM address (registered).
- mem_wdata  out  8  RAM write data (registered).
- mem_rdata  in  8  RAM read data, valid one clock after the mem_en cycle.

## Operation
- Slot phase: a 1-bit toggle flips on every sampled slot_en. After reset the next slot is V. slot_is_video reflects the toggle.
- Eligibility: a requester is eligible when its req is high and it has no outstanding access. There is one outstanding bit per requester. The bit is set on grant and cleared when the ack is issued.
- V-slot priority: video, then DMA, then idle.
- P-slot priority: CPU, then DMA, then idle. The exception is when starve_cnt == STARVE_LIMIT and DMA is eligible; DMA then wins over the CPU.
- starve_cnt (4 bit, saturating at STARVE_LIMIT):
  - Increments on a P-slot where DMA is eligible and the CPU is granted.
  - Clears to 0 on any DMA grant.
  - Is unchanged otherwise.
- Video never loses a V-slot it is eligible for. A video request made during a P-slot waits for the next V-slot.
- Idle slot: mem_en stays 0. The slot phase still toggles.
- Grant: mem_addr, mem_we and mem_wdata are taken from the winner. Video is always a read (mem_we = 0).
- Completion: the granted requester gets *_ack. For a read, *_rdata is latched from mem_rdata. For a write, *_rdata holds its previous value.
- Request level: req is a level. If req is still high at a slot after its ack, that is a new access. A requester must hold addr, we and wdata stable from asserting req until its ack.
- Reset mid-access: in-flight accesses are abandoned and no ack is issued.

## Timing
- Edge E0 samples slot_en = 1 and performs arbitration. mem_en/mem_we/mem_addr/mem_wdata are high/valid for exactly the one cycle after E0.
- Edge E1: the RAM captures the access. mem_rdata is valid in the cycle after E1.
- Edge E2: *_ack is high for exactly the one cycle after E2, with *_rdata valid from the same edge. Fixed latency is 2 clocks from the slot_en sample to ack.
- Slots may be issued on consecutive cycles. The pipeline stays full: up to two accesses are in flight, from different requesters.
- An outstanding requester is skipped, not stalled. Its slot falls through to the next priority.
- Reset values: all acks, mem_en, mem_we = 0. mem_addr, mem_wdata, all *_rdata = 0. slot_is_video = 1, starve_cnt = 0, outstanding bits = 0.
- slot_en while RESET is high is ignored. The first slot_en after release is a V-slot.

## Test plan
- Reset, then slot_en every 4 clocks with vid_req = 1, vid_addr = 0x1234, mem_rdata model returning 0xA5 -> V-slots show mem_en with addr 0x1234, and vid_ack/vid_data = 0xA5 exactly 2 clocks after each V slot_en. P-slots are idle.
- cpu_req write to 0x0100 with data 0x3C, in a P-slot -> mem_we = 1, addr 0x0100, wdata 0x3C for one cycle, cpu_ack 2 clocks later. A read-back in the next P-slot returns 0x3C.
- cpu_req and dma_req held high continuously, STARVE_LIMIT = 4 -> P-slot grants are CPU ×4, DMA ×1, repeating. starve_cnt returns to 0 after each DMA grant.
- vid_req = 0, dma_req = 1, slots back-to-back -> DMA is granted in the V-slot, skipped in the next slot while outstanding, then granted again after dma_ack. No double grant.
- Simultaneous vid_req, cpu_req and dma_req with slot_en on consecutive cycles -> V: video, P: CPU. Two accesses are overlapped in flight, and acks come out in grant order with correct data routing.
- RESET asserted in the cycle after a grant -> mem_en and acks drop to 0 at once, and no ack is produced for that access. The first slot after release is V.
